lsu_mem_stage: RTL and testbench

Load/store unit in the MEM stage, directly downstream of the 64-bit ALU. It takes the ALU result as the effective address for LDUR/STUR. It runs one data-memory transaction over a req/ack bus and holds the pipeline (stall) until the access completes or fails. It returns load data to the MEM/WB register and flags misaligned or timed-out accesses.

---
 rtl/lsu_mem_stage_if.sv | 21 ++
 rtl/lsu_mem_stage.sv | 100 ++++++++++
 tb/tb_lsu_mem_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - data-memory req/ack bus between the LSU and memory
interface lsu_mem_stage_if #(
  parameter int N = 64
);
  logic         bus_req;
  logic         bus_we;
  logic [N-1:0] bus_addr;
  logic [N-1:0] bus_wdata;
  logic         bus_ack;
  logic [N-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - MEM-stage load/store unit: one bus transaction per LDUR/STUR, stalls until done
module lsu_mem_stage #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic [N-1:0]     aluResult,
  input  logic [N-1:0]     writeData,
  output logic             stall,
  output logic [N-1:0]     readData,
  output logic             readValid,
  output logic             misaligned,
  output logic             busErr,
  lsu_mem_stage_if.master  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          op;
  logic          aligned;

  assign op      = memRead | memWrite;
  assign aligned = (aluResult[2:0] == 3'b000);

  // Stall is gated by reset so the pipeline is released the instant reset asserts.
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      case (state)
        S_IDLE:  stall = op & aligned;
        S_REQ:   stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      readData      <= '0;
      readValid     <= 1'b0;
      misaligned    <= 1'b0;
      busErr        <= 1'b0;
    end else begin
      readValid  <= 1'b0;
      misaligned <= 1'b0;
      busErr     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op) begin
            if (aligned) begin
              bus.bus_addr  <= aluResult;
              bus.bus_wdata <= writeData;
              bus.bus_we    <= memWrite;
              bus.bus_req   <= 1'b1;
              cnt           <= '0;
              state         <= S_REQ;
            end else begin
              misaligned <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // An ack in the final allowed cycle still completes the access.
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) begin
              readData  <= bus.bus_rdata;
              readValid <= 1'b1;
            end
            state <= S_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.bus_req <= 1'b0;
            busErr      <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;
  localparam int N       = 64;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         memRead, memWrite;
  logic [N-1:0] aluResult, writeData;
  logic         stall, readValid, misaligned, busErr;
  logic [N-1:0] readData;

  lsu_mem_stage_if #(.N(N)) bus_if ();

  lsu_mem_stage #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .aluResult  (aluResult),
    .writeData  (writeData),
    .stall      (stall),
    .readData   (readData),
    .readValid  (readValid),
    .misaligned (misaligned),
    .busErr     (busErr),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          ack_at;
    int          e_stall;
    int          e_req;
    bit          e_rv;
    bit          e_err;
    bit          e_mis;
    logic [63:0] e_rdata;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model_rd = 64'h0;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: whole-access outcome derived from the address, direction and ack delay.
  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    bit al = (v.addr[2:0] == 3'b000);
    bit ok = (v.ack_at >= 1) && (v.ack_at <= TIMEOUT);
    e.e_req   = al ? (ok ? v.ack_at : TIMEOUT) : 0;
    e.e_stall = al ? e.e_req + 1 : 0;
    e.e_rv    = al && !v.wr && ok;
    e.e_err   = al && !ok;
    e.e_mis   = !al;
    e.e_rdata = e.e_rv ? v.rdata : model_rd;
    return e;
  endfunction

  task automatic run_access(input vec_t v, input string tag);
    int n_stall = 0, n_req = 0, n_rv = 0, n_err = 0, n_mis = 0;
    bit tail = 0, done = 0;
    logic        s_we = 1'b0;
    logic [63:0] s_addr = '0, s_wdata = '0, rv_data = '0;
    memRead = v.rd; memWrite = v.wr; aluResult = v.addr; writeData = v.wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (readValid) begin n_rv++; rv_data = readData; end
      if (busErr) n_err++;
      if (misaligned) n_mis++;
      if (bus_if.bus_req) begin
        n_req++;
        if (n_req == 1) begin
          s_we = bus_if.bus_we; s_addr = bus_if.bus_addr; s_wdata = bus_if.bus_wdata;
        end
        if (n_req == v.ack_at) begin
          bus_if.bus_ack = 1'b1; bus_if.bus_rdata = v.rdata;
        end
      end
      if (tail) done = 1;
      else if (!stall) tail = 1;
      @(posedge clk); #2;
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = {$urandom(), $urandom()};
      if (tail) begin memRead = 1'b0; memWrite = 1'b0; end
    end
    if (!done) chk({tag, " window"}, 64'd0, 64'd1);
    chk({tag, " stall cycles"}, 64'(n_stall), 64'(v.e_stall));
    chk({tag, " req cycles"},   64'(n_req),   64'(v.e_req));
    chk({tag, " readValid"},    64'(n_rv),    64'(v.e_rv));
    chk({tag, " busErr"},       64'(n_err),   64'(v.e_err));
    chk({tag, " misaligned"},   64'(n_mis),   64'(v.e_mis));
    chk({tag, " readData"},     readData,     v.e_rdata);
    if (v.e_rv) chk({tag, " pulse data"}, rv_data, v.e_rdata);
    if (v.e_req > 0) begin
      chk({tag, " bus_we"},   64'(s_we), 64'(v.wr));
      chk({tag, " bus_addr"}, s_addr,    v.addr);
      if (v.wr) chk({tag, " bus_wdata"}, s_wdata, v.wdata);
    end
    model_rd = v.e_rdata;
  endtask

  initial begin
    rst_n = 1'b0;
    memRead = 1'b1; memWrite = 1'b0; aluResult = '0; writeData = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall",     64'(stall), 64'd0);
    chk("reset bus_req",   64'(bus_if.bus_req), 64'd0);
    chk("reset bus_addr",  bus_if.bus_addr, 64'd0);
    chk("reset readData",  readData, 64'd0);
    chk("reset readValid", 64'(readValid), 64'd0);
    memRead = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    //          rd    wr    addr   wdata   rdata                  ack stl req rv    err   mis   e_rdata
    tbl[0] = '{1'b1, 1'b0, 64'h10, 64'h0,   64'hDEADBEEFCAFEF00D, 3,  4,  3,  1'b1, 1'b0, 1'b0, 64'hDEADBEEFCAFEF00D};
    tbl[1] = '{1'b0, 1'b1, 64'h08, 64'h123, 64'h0,                1,  2,  1,  1'b0, 1'b0, 1'b0, 64'hDEADBEEFCAFEF00D};
    tbl[2] = '{1'b1, 1'b0, 64'h0C, 64'h0,   64'h0,                1,  0,  0,  1'b0, 1'b0, 1'b1, 64'hDEADBEEFCAFEF00D};
    tbl[3] = '{1'b1, 1'b0, 64'h20, 64'h0,   64'h1111,             0,  17, 16, 1'b0, 1'b1, 1'b0, 64'hDEADBEEFCAFEF00D};
    tbl[4] = '{1'b0, 1'b1, 64'h07, 64'h55,  64'h0,                1,  0,  0,  1'b0, 1'b0, 1'b1, 64'hDEADBEEFCAFEF00D};
    tbl[5] = '{1'b1, 1'b0, 64'h30, 64'h0,   64'h5555AAAA0000FFFF, 16, 17, 16, 1'b1, 1'b0, 1'b0, 64'h5555AAAA0000FFFF};
    for (int i = 0; i < 6; i++) run_access(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int   k = $urandom_range(0, 2);
      v.rd = (k != 1); v.wr = (k != 0);
      v.addr = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) v.addr[2:0] = 3'b000;
      else if (v.addr[2:0] == 3'b000) v.addr[0] = 1'b1;
      v.wdata = {$urandom(), $urandom()};
      v.rdata = {$urandom(), $urandom()};
      v.ack_at = $urandom_range(0, TIMEOUT + 2);
      run_access(model(v), $sformatf("rnd%0d", i));
    end

    // Both strobes high is a write; a load issued right after DONE starts at once.
    memRead = 1'b1; memWrite = 1'b1; aluResult = 64'h18; writeData = 64'hA5A5;
    @(negedge clk);
    chk("b2b idle stall", 64'(stall), 64'd1);
    chk("b2b idle req",   64'(bus_if.bus_req), 64'd0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("b2b wr req",  64'(bus_if.bus_req), 64'd1);
    chk("b2b wr we",   64'(bus_if.bus_we), 64'd1);
    chk("b2b wr addr", bus_if.bus_addr, 64'h18);
    bus_if.bus_ack = 1'b1;
    @(posedge clk); #2;
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    chk("b2b wr done stall", 64'(stall), 64'd0);
    chk("b2b wr done req",   64'(bus_if.bus_req), 64'd0);
    chk("b2b wr done rv",    64'(readValid), 64'd0);
    @(posedge clk); #2;
    memWrite = 1'b0; memRead = 1'b1; aluResult = 64'h20;
    @(negedge clk);
    chk("b2b rd idle stall", 64'(stall), 64'd1);
    @(posedge clk); #2;
    @(negedge clk);
    chk("b2b rd req",  64'(bus_if.bus_req), 64'd1);
    chk("b2b rd we",   64'(bus_if.bus_we), 64'd0);
    chk("b2b rd addr", bus_if.bus_addr, 64'h20);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 64'h0123456789ABCDEF;
    @(posedge clk); #2;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    @(negedge clk);
    chk("b2b rd valid", 64'(readValid), 64'd1);
    chk("b2b rd data",  readData, 64'h0123456789ABCDEF);
    chk("b2b rd stall", 64'(stall), 64'd0);
    @(posedge clk); #2;
    memRead = 1'b0;
    @(negedge clk);
    chk("b2b after rv", 64'(readValid), 64'd0);

    // Asynchronous reset in the second REQ cycle, then a stray ack in IDLE.
    @(posedge clk); #2;
    memRead = 1'b1; aluResult = 64'h40;
    @(posedge clk); #2;
    @(posedge clk); #3;
    chk("rst pre req",   64'(bus_if.bus_req), 64'd1);
    chk("rst pre stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async req",   64'(bus_if.bus_req), 64'd0);
    chk("rst async stall", 64'(stall), 64'd0);
    memRead = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst idle outputs",
        {bus_if.bus_req, bus_if.bus_we, stall, readValid, misaligned, busErr}, 64'd0);
    chk("rst idle addr",  bus_if.bus_addr, 64'd0);
    chk("rst idle wdata", bus_if.bus_wdata, 64'd0);
    chk("rst idle rdata", readData, 64'd0);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 64'hFFFF0000FFFF0000;
    @(posedge clk); #2;
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    chk("late ack req",   64'(bus_if.bus_req), 64'd0);
    chk("late ack rv",    64'(readValid), 64'd0);
    chk("late ack rdata", readData, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule
